// File: rtl/ct_ifu_icache_refill_writer_pkg.sv
// Shared definitions for the I-cache refill writer: FSM states, beat-word layout and
// index field positions. The parity helper exists only with ICACHE_REFILL_PARITY_EN.
package ct_ifu_icache_refill_writer_pkg;

  localparam int BEATS_PER_LINE = 4;
  localparam int BEAT_DATA_W    = 128;
  localparam int BEAT_W         = BEAT_DATA_W + 2;
  localparam int SET_W          = 11;
  localparam int INDEX_W        = 16;
  localparam int ACC_CNT_W      = 3;

  localparam int IDX_SET_LSB  = 5;
  localparam int IDX_SET_MSB  = 15;
  localparam int IDX_BEAT_LSB = 3;
  localparam int IDX_BEAT_MSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ABORT = 2'd3
  } refill_state_e;

  typedef struct packed {
    logic [BEAT_DATA_W-1:0] data;
    logic                   err;
    logic                   last;
  } beat_word_t;

  function automatic logic [INDEX_W-1:0] make_index(input logic [SET_W-1:0] set_idx,
                                                    input logic [1:0]       beat);
    logic [INDEX_W-1:0] idx;
    idx                              = '0;
    idx[IDX_SET_MSB:IDX_SET_LSB]     = set_idx;
    idx[IDX_BEAT_MSB:IDX_BEAT_LSB]   = beat;
    return idx;
  endfunction

`ifdef ICACHE_REFILL_PARITY_EN
  // Bank 0 is the most significant 32-bit slice; par[i] covers bank i.
  function automatic logic [3:0] bank_parity(input logic [BEAT_DATA_W-1:0] d);
    logic [3:0] p;
    for (int b = 0; b < 4; b++) begin
      p[b] = ^d[BEAT_DATA_W-1-32*b -: 32];
    end
    return p;
  endfunction
`endif

endpackage

// File: rtl/ct_ifu_icache_refill_writer_beat_fifo.sv
// Two-entry beat FIFO between the refill bus and the array write port.
// Push and pop may happen together while full; flush empties it in one cycle.
module ct_ifu_refill_beat_fifo
  import ct_ifu_icache_refill_writer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [BEAT_W-1:0] din,
  output logic [BEAT_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [BEAT_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Payload storage carries no reset; the pointers and count decide validity.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/ct_ifu_icache_refill_writer.sv
// I-cache refill writer: buffers four 128-bit beats per line and writes them into the
// selected data array, yielding to fetch. Define ICACHE_REFILL_PARITY_EN for bank parity.
module ct_ifu_icache_refill_writer
  import ct_ifu_icache_refill_writer_pkg::*;
(
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   refill_req_vld,
  output logic                   refill_req_rdy,
  input  logic [SET_W-1:0]       refill_req_idx,
  input  logic                   refill_req_way,
  input  logic                   beat_vld,
  output logic                   beat_rdy,
  input  logic [BEAT_DATA_W-1:0] beat_data,
  input  logic                   beat_err,
  input  logic                   beat_last,
  input  logic                   ifu_fetch_req,
  output logic                   ifu_icache_data_array0_cen_b,
  output logic                   ifu_icache_data_array0_clk_en,
  output logic                   ifu_icache_data_array1_cen_b,
  output logic                   ifu_icache_data_array1_clk_en,
  output logic                   ifu_icache_data_wen_b,
  output logic [BEAT_DATA_W-1:0] ifu_icache_data_din,
  output logic [INDEX_W-1:0]     ifu_icache_index,
  output logic [3:0]             ifu_icache_data_par,
  output logic                   refill_done,
  output logic                   refill_err,
  output logic                   refill_busy
);

  localparam logic [ACC_CNT_W-1:0] LAST_ACC = ACC_CNT_W'(BEATS_PER_LINE - 1);

  refill_state_e        state;
  logic [SET_W-1:0]     req_idx;
  logic                 req_way;
  logic [1:0]           beat_cnt;
  logic [ACC_CNT_W-1:0] acc_cnt;
  logic                 last_seen;
  logic                 done_q;
  logic                 err_q;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_flush;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [BEAT_W-1:0]    fifo_dout;
  beat_word_t           push_word;
  beat_word_t           head;

  logic                 writing;
  logic                 fire;
  logic                 head_err;
  logic                 req_acc;
  logic                 beat_acc;
  logic                 fill_acc;
  logic                 fourth_beat;
  logic                 proto_err;
  logic                 abort_now;
  logic                 line_done;

  assign head      = fifo_dout;
  assign push_word = '{data: beat_data, err: beat_err, last: beat_last};

  assign refill_req_rdy = (state == ST_IDLE);
  assign beat_rdy       = ((state == ST_FILL) && !fifo_full) ||
                          ((state == ST_ABORT) && !last_seen);

  assign req_acc     = refill_req_vld && refill_req_rdy;
  assign beat_acc    = beat_vld && beat_rdy;
  assign fill_acc    = beat_acc && (state == ST_FILL);
  assign fourth_beat = (acc_cnt == LAST_ACC);
  assign proto_err   = fill_acc && (beat_last != fourth_beat);

  assign writing   = (state == ST_FILL) || (state == ST_DRAIN);
  assign fire      = writing && !fifo_empty && !head.err && !ifu_fetch_req;
  assign head_err  = writing && !fifo_empty && head.err;
  assign abort_now = head_err || proto_err;
  // Only the fourth beat can sit in the FIFO with last set, so its write ends the line.
  assign line_done = fire && head.last;

  assign fifo_push  = fill_acc && !abort_now;
  assign fifo_pop   = fire;
  assign fifo_flush = req_acc || abort_now;

  ct_ifu_refill_beat_fifo u_beat_fifo (
    .clk   (forever_cpuclk),
    .rst_n (cpurst_b),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (push_word),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state     <= ST_IDLE;
      req_idx   <= '0;
      req_way   <= 1'b0;
      beat_cnt  <= 2'd0;
      acc_cnt   <= '0;
      last_seen <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_acc) begin
            req_idx   <= refill_req_idx;
            req_way   <= refill_req_way;
            beat_cnt  <= 2'd0;
            acc_cnt   <= '0;
            last_seen <= 1'b0;
            state     <= ST_FILL;
          end
        end
        ST_FILL, ST_DRAIN: begin
          if (fire) begin
            beat_cnt <= beat_cnt + 2'd1;
          end
          if (fill_acc) begin
            acc_cnt <= acc_cnt + 1'b1;
            if (beat_last) begin
              last_seen <= 1'b1;
            end
          end
          if (abort_now) begin
            state <= ST_ABORT;
          end else if (line_done) begin
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else if (fill_acc && fourth_beat) begin
            state <= ST_DRAIN;
          end
        end
        ST_ABORT: begin
          // Beats are swallowed until the bus closes the line with a last beat.
          if (last_seen || (beat_acc && beat_last)) begin
            err_q <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ifu_icache_data_array0_cen_b  = 1'b1;
    ifu_icache_data_array0_clk_en = 1'b0;
    ifu_icache_data_array1_cen_b  = 1'b1;
    ifu_icache_data_array1_clk_en = 1'b0;
    ifu_icache_data_wen_b         = 1'b1;
    ifu_icache_data_din           = '0;
    ifu_icache_index              = '0;
    if (fire) begin
      ifu_icache_data_wen_b = 1'b0;
      ifu_icache_data_din   = head.data;
      ifu_icache_index      = make_index(req_idx, beat_cnt);
      if (req_way) begin
        ifu_icache_data_array1_cen_b  = 1'b0;
        ifu_icache_data_array1_clk_en = 1'b1;
      end else begin
        ifu_icache_data_array0_cen_b  = 1'b0;
        ifu_icache_data_array0_clk_en = 1'b1;
      end
    end
  end

`ifdef ICACHE_REFILL_PARITY_EN
  assign ifu_icache_data_par = bank_parity(ifu_icache_data_din);
`else
  assign ifu_icache_data_par = 4'b0000;
`endif

  assign refill_done = done_q;
  assign refill_err  = err_q;
  assign refill_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_ct_ifu_icache_refill_writer.sv
// Scoreboard bench for the refill writer: the stimulus side pushes expected array
// writes and line outcomes, a negedge monitor pops and compares them.
module tb_ct_ifu_icache_refill_writer;

  logic         forever_cpuclk = 1'b0;
  logic         cpurst_b;
  logic         refill_req_vld;
  logic         refill_req_rdy;
  logic [10:0]  refill_req_idx;
  logic         refill_req_way;
  logic         beat_vld;
  logic         beat_rdy;
  logic [127:0] beat_data;
  logic         beat_err;
  logic         beat_last;
  logic         ifu_fetch_req;
  logic         ifu_icache_data_array0_cen_b;
  logic         ifu_icache_data_array0_clk_en;
  logic         ifu_icache_data_array1_cen_b;
  logic         ifu_icache_data_array1_clk_en;
  logic         ifu_icache_data_wen_b;
  logic [127:0] ifu_icache_data_din;
  logic [15:0]  ifu_icache_index;
  logic [3:0]   ifu_icache_data_par;
  logic         refill_done;
  logic         refill_err;
  logic         refill_busy;

  typedef struct {
    bit           way;
    logic [15:0]  index;
    logic [127:0] data;
  } wr_t;

`ifdef ICACHE_REFILL_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  wr_t          exp_wr[$];
  bit           exp_evt[$];
  wr_t          mon_w;
  bit           mon_e;
  int           checks = 0;
  int           errors = 0;
  bit           mon_en = 1'b0;
  bit           fetch_rand_en = 1'b0;
  logic         fetch_force = 1'b0;
  logic         fetch_rnd = 1'b0;
  logic [127:0] line_data[5];

  always #5 forever_cpuclk = ~forever_cpuclk;

  assign ifu_fetch_req = fetch_force | fetch_rnd;

  ct_ifu_icache_refill_writer dut (
    .forever_cpuclk                (forever_cpuclk),
    .cpurst_b                      (cpurst_b),
    .refill_req_vld                (refill_req_vld),
    .refill_req_rdy                (refill_req_rdy),
    .refill_req_idx                (refill_req_idx),
    .refill_req_way                (refill_req_way),
    .beat_vld                      (beat_vld),
    .beat_rdy                      (beat_rdy),
    .beat_data                     (beat_data),
    .beat_err                      (beat_err),
    .beat_last                     (beat_last),
    .ifu_fetch_req                 (ifu_fetch_req),
    .ifu_icache_data_array0_cen_b  (ifu_icache_data_array0_cen_b),
    .ifu_icache_data_array0_clk_en (ifu_icache_data_array0_clk_en),
    .ifu_icache_data_array1_cen_b  (ifu_icache_data_array1_cen_b),
    .ifu_icache_data_array1_clk_en (ifu_icache_data_array1_clk_en),
    .ifu_icache_data_wen_b         (ifu_icache_data_wen_b),
    .ifu_icache_data_din           (ifu_icache_data_din),
    .ifu_icache_index              (ifu_icache_index),
    .ifu_icache_data_par           (ifu_icache_data_par),
    .refill_done                   (refill_done),
    .refill_err                    (refill_err),
    .refill_busy                   (refill_busy)
  );

  // Even parity per 32-bit bank, bank 0 being the top slice of the beat.
  function automatic logic [3:0] expPar(input logic [127:0] d);
    logic [3:0] p;
    p = 4'b0;
    for (int i = 0; i < 4; i++) begin
      p[i] = PAR_EN & (^d[127-32*i -: 32]);
    end
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_req_rdy"}, refill_req_rdy, 1);
    checkOutput({tag, "_beat_rdy"}, beat_rdy, 0);
    checkOutput({tag, "_strobes"}, {ifu_icache_data_array0_cen_b, ifu_icache_data_array1_cen_b,
                ifu_icache_data_array0_clk_en, ifu_icache_data_array1_clk_en,
                ifu_icache_data_wen_b}, 5'b11001);
    checkOutput({tag, "_din"}, ifu_icache_data_din, 0);
    checkOutput({tag, "_index"}, ifu_icache_index, 0);
    checkOutput({tag, "_par"}, ifu_icache_data_par, 0);
    checkOutput({tag, "_pulses_busy"}, {refill_done, refill_err, refill_busy}, 0);
  endtask

  // Fetch noise, only enabled for lines whose write count does not depend on timing.
  always @(posedge forever_cpuclk) begin
    #1;
    fetch_rnd = fetch_rand_en ? ($urandom_range(0, 2) == 0) : 1'b0;
  end

  always @(negedge forever_cpuclk) begin
    if (mon_en && cpurst_b) begin
      if (!ifu_icache_data_array0_cen_b || !ifu_icache_data_array1_cen_b) begin
        checkOutput("write_during_fetch", ifu_fetch_req, 0);
        checkOutput("one_array_enabled",
                    ifu_icache_data_array0_cen_b ^ ifu_icache_data_array1_cen_b, 1);
        checkOutput("busy_while_writing", refill_busy, 1);
        checkOutput("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          mon_w = exp_wr.pop_front();
          if (mon_w.way) begin
            checkOutput("array1_strobes", {ifu_icache_data_array1_cen_b, ifu_icache_data_array1_clk_en,
                        ifu_icache_data_array0_cen_b, ifu_icache_data_array0_clk_en,
                        ifu_icache_data_wen_b}, 5'b01100);
          end else begin
            checkOutput("array0_strobes", {ifu_icache_data_array0_cen_b, ifu_icache_data_array0_clk_en,
                        ifu_icache_data_array1_cen_b, ifu_icache_data_array1_clk_en,
                        ifu_icache_data_wen_b}, 5'b01100);
          end
          checkOutput("write_index", ifu_icache_index, mon_w.index);
          checkOutput("write_din", ifu_icache_data_din, mon_w.data);
          checkOutput("write_par", ifu_icache_data_par, expPar(mon_w.data));
        end
      end else begin
        checkOutput("idle_strobes", {ifu_icache_data_array0_cen_b, ifu_icache_data_array1_cen_b,
                    ifu_icache_data_array0_clk_en, ifu_icache_data_array1_clk_en,
                    ifu_icache_data_wen_b}, 5'b11001);
      end
      if (refill_done || refill_err) begin
        checkOutput("single_outcome", refill_done & refill_err, 0);
        checkOutput("writes_before_outcome", exp_wr.size(), 0);
        exp_wr.delete();
        checkOutput("outcome_expected", exp_evt.size() != 0, 1);
        if (exp_evt.size() != 0) begin
          mon_e = exp_evt.pop_front();
          checkOutput("outcome_is_err", refill_err, mon_e);
        end
      end
    end
  end

  task automatic send_req(input bit way, input logic [10:0] idx);
    int n;
    n = 0;
    refill_req_vld = 1'b1;
    refill_req_way = way;
    refill_req_idx = idx;
    @(negedge forever_cpuclk);
    while (!refill_req_rdy && n < 300) begin
      n++;
      @(negedge forever_cpuclk);
    end
    checkOutput("req_rdy_timeout", refill_req_rdy, 1);
    @(posedge forever_cpuclk);
    #1 refill_req_vld = 1'b0;
  endtask

  task automatic send_beat(input logic [127:0] d, input bit e, input bit l, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      @(posedge forever_cpuclk);
      #1;
    end
    beat_vld  = 1'b1;
    beat_data = d;
    beat_err  = e;
    beat_last = l;
    @(negedge forever_cpuclk);
    while (!beat_rdy && n < 300) begin
      n++;
      @(negedge forever_cpuclk);
    end
    checkOutput("beat_rdy_timeout", beat_rdy, 1);
    @(posedge forever_cpuclk);
    #1 beat_vld = 1'b0;
  endtask

  task automatic wait_line_end();
    int n;
    n = 0;
    while (exp_evt.size() != 0 && n < 400) begin
      @(negedge forever_cpuclk);
      #1;
      n++;
    end
    checkOutput("line_end_timeout", exp_evt.size(), 0);
    @(posedge forever_cpuclk);
    #1;
  endtask

  // kind 0: clean line; 1: bus error on beat k; 2: last on beat k (k<4); 3: no last on beat 4.
  task automatic applyStimulus(input bit way, input logic [10:0] idx, input int kind,
                               input int k, input int gap_max);
    int  nbeats;
    int  nwr;
    wr_t w;
    nbeats = (kind == 2) ? k : ((kind == 3) ? 5 : 4);
    nwr    = (kind == 0) ? 4 : ((kind == 3) ? 3 : k - 1);
    for (int i = 0; i < nwr; i++) begin
      w.way   = way;
      w.index = 16'(idx) * 16'd32 + 16'(i * 8);
      w.data  = line_data[i];
      exp_wr.push_back(w);
    end
    exp_evt.push_back(kind != 0);
    send_req(way, idx);
    for (int i = 0; i < nbeats; i++) begin
      bit e;
      bit l;
      e = (kind == 1) && (i == k - 1);
      l = (i == nbeats - 1);
      send_beat(line_data[i], e, l, int'($urandom_range(0, gap_max)));
    end
    wait_line_end();
  endtask

  task automatic randomLine();
    for (int i = 0; i < 5; i++) begin
      line_data[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int kind;
    int k;
    cpurst_b       = 1'b0;
    refill_req_vld = 1'b0;
    refill_req_idx = '0;
    refill_req_way = 1'b0;
    beat_vld       = 1'b0;
    beat_data      = '0;
    beat_err       = 1'b0;
    beat_last      = 1'b0;
    #2 checkResetValues("reset");
    repeat (2) @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    @(posedge forever_cpuclk);
    #1 mon_en = 1'b1;

    $display("[TB] full refill way1 idx 0x155");
    for (int i = 0; i < 4; i++) line_data[i] = {4{32'hA000_0000 + 32'(i)}};
    applyStimulus(1'b1, 11'h155, 0, 0, 0);

    $display("[TB] fetch contention");
    randomLine();
    fork
      applyStimulus(1'b0, 11'h2A3, 0, 0, 0);
      begin
        repeat (3) @(posedge forever_cpuclk);
        #1 fetch_force = 1'b1;
        repeat (5) @(negedge forever_cpuclk);
        checkOutput("beat_rdy_stalled", beat_rdy, 0);
        @(posedge forever_cpuclk);
        #1 fetch_force = 1'b0;
      end
    join

    $display("[TB] bus error on beat 2");
    randomLine();
    applyStimulus(1'b1, 11'h010, 1, 2, 0);

    $display("[TB] early last on beat 3");
    randomLine();
    applyStimulus(1'b0, 11'h7FF, 2, 3, 0);

    $display("[TB] missing last on beat 4");
    randomLine();
    applyStimulus(1'b1, 11'h001, 3, 4, 1);

    $display("[TB] async reset during beat 2");
    mon_en = 1'b0;
    randomLine();
    send_req(1'b0, 11'h003);
    send_beat(line_data[0], 1'b0, 1'b0, 0);
    beat_vld  = 1'b1;
    beat_data = line_data[1];
    @(negedge forever_cpuclk);
    #2 cpurst_b = 1'b0;
    #1 checkResetValues("midline_reset");
    beat_vld = 1'b0;
    repeat (2) @(negedge forever_cpuclk);
    cpurst_b = 1'b1;
    exp_wr.delete();
    exp_evt.delete();
    @(posedge forever_cpuclk);
    #1 mon_en = 1'b1;
    randomLine();
    applyStimulus(1'b0, 11'h003, 0, 0, 0);

    $display("[TB] parity patterns");
    randomLine();
    line_data[0] = 128'h7;
    line_data[1] = 128'h0;
    applyStimulus(1'b1, 11'h444, 0, 0, 0);

    $display("[TB] random lines");
    for (int n = 0; n < 24; n++) begin
      randomLine();
      kind = int'($urandom_range(0, 3));
      k    = (kind == 1) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 3));
      fetch_rand_en = (kind == 0);
      applyStimulus(1'($urandom), 11'($urandom), kind, k, 2);
      fetch_rand_en = 1'b0;
    end

    repeat (3) @(posedge forever_cpuclk);
    #1;
    checkOutput("writes_left", exp_wr.size(), 0);
    checkOutput("outcomes_left", exp_evt.size(), 0);
    checkOutput("final_idle", {refill_busy, refill_req_rdy}, 2'b01);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
